// File: rtl/tone_pkg.sv
// Shared note codes, tone frequencies and period helpers for the tone
// generator / tone detector pair.
package tone_pkg;

  typedef logic [3:0] note_t;

  localparam note_t NOTE_SILENT = 4'd0;
  localparam note_t NOTE_C      = 4'd1;
  localparam note_t NOTE_D      = 4'd2;
  localparam note_t NOTE_E      = 4'd3;
  localparam note_t NOTE_F      = 4'd4;
  localparam note_t NOTE_G      = 4'd5;
  localparam note_t NOTE_A      = 4'd6;
  localparam note_t NOTE_AS     = 4'd7;
  localparam note_t NOTE_B      = 4'd8;
  localparam note_t NOTE_C5     = 4'd9;
  localparam note_t NOTE_UNK    = 4'd15;

  // Tone frequencies in Hz, identical to the ones the generator plays.
  localparam int FREQ_C  = 262;
  localparam int FREQ_D  = 294;
  localparam int FREQ_E  = 330;
  localparam int FREQ_F  = 349;
  localparam int FREQ_G  = 392;
  localparam int FREQ_A  = 440;
  localparam int FREQ_AS = 466;
  localparam int FREQ_B  = 494;
  localparam int FREQ_C5 = 523;

  localparam int PERIOD_W = 18;

  typedef enum logic [1:0] {
    S_SILENT,
    S_ARMED,
    S_TRACK
  } det_state_t;

  // Nominal tone period in clock cycles, truncated.
  function automatic int nom_period(int clk_hz, int freq);
    return clk_hz / freq;
  endfunction

  // Frequency belonging to a legal note code; 1 keeps the divide safe.
  function automatic int note_freq(note_t code);
    case (code)
      NOTE_C:  return FREQ_C;
      NOTE_D:  return FREQ_D;
      NOTE_E:  return FREQ_E;
      NOTE_F:  return FREQ_F;
      NOTE_G:  return FREQ_G;
      NOTE_A:  return FREQ_A;
      NOTE_AS: return FREQ_AS;
      NOTE_B:  return FREQ_B;
      NOTE_C5: return FREQ_C5;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/tone_detector_if.sv
// Tone input plus the decoded note outputs of the tone detector.
interface tone_detector_if;
  import tone_pkg::*;

  logic                tone_in;
  note_t               note;
  logic                note_valid;
  logic                note_change;
  logic [PERIOD_W-1:0] period;

  modport master (
    output tone_in,
    input  note,
    input  note_valid,
    input  note_change,
    input  period
  );

  modport slave (
    input  tone_in,
    output note,
    output note_valid,
    output note_change,
    output period
  );

endinterface

// File: rtl/tone_detector_classifier.sv
// Maps a measured tone period onto a note code; anything outside every
// tolerance window is reported as unknown.
module period_classifier
  import tone_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int TOL_SHIFT = 6
) (
  input  logic [PERIOD_W-1:0] i_period,
  output note_t               o_code
);

  function automatic note_t classify(logic [PERIOD_W-1:0] p);
    note_t code;
    int    pv;
    int    nom;
    int    tol;
    code = NOTE_UNK;
    pv   = int'(p);
    for (int k = 1; k <= 9; k++) begin
      nom = nom_period(CLK_HZ, note_freq(note_t'(k)));
      tol = nom >> TOL_SHIFT;
      if ((pv >= nom - tol) && (pv <= nom + tol)) begin
        code = note_t'(k);
      end
    end
    return code;
  endfunction

  assign o_code = classify(i_period);

endmodule

// File: rtl/tone_detector.sv
// Measures the rising-edge period of an asynchronous square-wave tone,
// classifies it and reports a debounced note code.
module tone_detector
  import tone_pkg::*;
#(
  parameter int CLK_HZ         = 12000000,
  parameter int TIMEOUT_CYCLES = 120000,
  parameter int STABLE_COUNT   = 4,
  parameter int TOL_SHIFT      = 6
) (
  input logic            clk,
  input logic            rst_n,
  tone_detector_if.slave bus
);

  localparam logic [PERIOD_W-1:0] CNT_MAX   = PERIOD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]          MATCH_MAX = 4'(STABLE_COUNT);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_sync3;
  logic                w_rise;
  logic                w_timeout;
  logic                w_capture;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_capPeriod;
  note_t               w_code;

  det_state_t          r_state;
  note_t               r_note;
  note_t               r_lastCode;
  logic [3:0]          r_matchCnt;
  logic                r_noteValid;
  logic                r_noteChange;
  logic [PERIOD_W-1:0] r_period;

  // Two-stage synchronizer plus a delay stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= bus.tone_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync3;

  // Cycles since the last rising edge, parked at the timeout value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + PERIOD_W'(1);
    end
  end

  assign w_timeout   = (r_cnt == CNT_MAX) && !w_rise;
  assign w_capPeriod = r_cnt + PERIOD_W'(1);
  assign w_capture   = w_rise && (r_state != S_SILENT);

  period_classifier #(
    .CLK_HZ    (CLK_HZ),
    .TOL_SHIFT (TOL_SHIFT)
  ) u_classifier (
    .i_period (w_capPeriod),
    .o_code   (w_code)
  );

  // Tracking FSM, capture/debounce and the registered note outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_SILENT;
      r_note       <= NOTE_SILENT;
      r_lastCode   <= NOTE_SILENT;
      r_matchCnt   <= '0;
      r_noteValid  <= 1'b0;
      r_noteChange <= 1'b0;
      r_period     <= '0;
    end else begin
      r_noteChange <= 1'b0;

      case (r_state)
        S_SILENT: begin
          if (w_rise) begin
            r_state <= S_ARMED;
          end
        end
        S_ARMED, S_TRACK: begin
          if (w_rise) begin
            r_state <= S_TRACK;
          end else if (w_timeout) begin
            r_state <= S_SILENT;
          end
        end
        default: r_state <= S_SILENT;
      endcase

      if (w_timeout && (r_state != S_SILENT)) begin
        r_note       <= NOTE_SILENT;
        r_noteValid  <= 1'b0;
        r_matchCnt   <= '0;
        r_noteChange <= (r_note != NOTE_SILENT);
      end else begin
        if (w_capture) begin
          r_period <= w_capPeriod;
          if (w_code == r_lastCode) begin
            if (r_matchCnt < MATCH_MAX) begin
              r_matchCnt <= r_matchCnt + 4'd1;
            end
          end else begin
            r_lastCode <= w_code;
            r_matchCnt <= 4'd1;
          end
        end
        if ((r_matchCnt == MATCH_MAX) && (r_lastCode != r_note) && !r_noteChange) begin
          r_note       <= r_lastCode;
          r_noteValid  <= (r_lastCode >= NOTE_C) && (r_lastCode <= NOTE_C5);
          r_noteChange <= 1'b1;
        end
      end
    end
  end

  assign bus.note        = r_note;
  assign bus.note_valid  = r_noteValid;
  assign bus.note_change = r_noteChange;
  assign bus.period      = r_period;

endmodule
